seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
Parametrised N-digit multiplexed seven-segment scan driver; successor to the two-digit scanner.
Cycles through NUM_DIGITS packed segment patterns, one digit per refresh period, and drives the shared segment bus plus a one-hot digit enable.
Adds enable/pause, per-digit blanking, a frame-done pulse and optional PWM dimming.
Sits between display-formatting logic and the board-level segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
SEG_W, 7, segment bits per digit
PERIOD, 500, dwell in cycles minus one; each digit is shown PERIOD+1 cycles
CBITS, $clog2(PERIOD+1), refresh counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk)
digits_in  input  NUM_DIGITS*SEG_W  packed patterns; digit k = digits_in[k*SEG_W +: SEG_W]
enable  input  1  1 = scan runs; 0 = counter and outputs frozen
blank_mask  input  NUM_DIGITS  bit k = 1 forces digit k dark
segment  output  SEG_W  segment pattern of current digit, active-high
digit_sel  output  NUM_DIGITS  one-hot enable of current digit, active-high
digit_idx  output  $clog2(NUM_DIGITS)  index of current digit
sig  output  1  one-cycle pulse on every digit advance
frame_done  output  1  one-cycle pulse when the index wraps NUM_DIGITS-1 -> 0

Behaviour:
- Reset (rst=0): cnt=0, digit_idx=NUM_DIGITS-1, segment=0, digit_sel=0 (all dark), sig=0, frame_done=0.
- State: cnt (0..PERIOD) and digit_idx. No other FSM.
- enable=1, cnt<PERIOD: cnt+1; sig=0, frame_done=0; segment, digit_sel and digit_idx hold.
- enable=1, cnt==PERIOD (advance): cnt=0; digit_idx = (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1; sig=1 for one cycle.
  - Same edge: digit_sel = one-hot(new idx); segment = blank_mask[new] ? 0 : digits_in slice[new].
  - frame_done=1 on that cycle only when new idx==0.
- First advance is on the (PERIOD+1)th rising edge after reset release and selects digit 0.
- Digit patterns and blank_mask are sampled only on advance edges; changes between advances are not visible until the next advance.
- enable=0: cnt, digit_idx, segment and digit_sel hold; sig=0, frame_done=0. On enable=1 the count resumes from the held value.
- enable=0 on the cycle cnt==PERIOD: no advance occurs. The advance happens on the first enabled edge instead.
- Reset mid-scan: all state returns to reset values at once; segment and digit_sel go dark asynchronously.
- All outputs are registered. Exception: segment under the dimming feature (see Optional Feature).

Optional Feature:
- Macro: SEVEN_SEG_DIMMING_EN.
- Defined: extra input port duty [CBITS-1:0]. segment = seg_q when cnt < duty, else 0. This is a combinational AND of registered seg_q with the compare (cnt < duty).
  - duty=0: always dark.
  - duty >= PERIOD+1: fully on.
  - digit_sel is unaffected.
- Undefined: no duty port; segment = seg_q directly.

Decomposition:
- Package seven_seg_pkg: SEG_W default and blank pattern constant SEG_OFF = '0.
- Same package: function onehot(idx), and hex-to-segment lookup constants for upstream users.
- One sub-module, seven_seg_refresh_timer: cnt plus advance-pulse generator with enable, parametrised by PERIOD.
- Scan/index/mux logic stays in the top module.

Test Plan:
- NUM_DIGITS=3, PERIOD=4, digits_in={7'h4F,7'h5B,7'h06}, enable=1: release reset -> first sig on edge 5, digit_sel=3'b001, segment=7'h06; then 3'b010/7'h5B at edge 10, 3'b100/7'h4F at edge 15; frame_done=1 at edge 20 with idx=0.
- Hold rst=0: outputs 0, digit_sel=0. Assert rst=0 mid-dwell at cnt=2 -> outputs dark in the same cycle, next advance 5 edges after release.
- enable=0 for 7 cycles at cnt=3 -> no sig, outputs held; re-enable -> advance after exactly 2 more edges.
- blank_mask=3'b010 -> digit 1 shows segment=0 with digit_sel=3'b010; digits 0 and 2 unaffected.
- Change digits_in mid-dwell -> segment unchanged until the next advance, which shows the new value.
- SEVEN_SEG_DIMMING_EN, PERIOD=4, duty=2 -> segment non-zero only while cnt in {0,1}. duty=0 -> always 0. duty=5 -> always on.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver and its upstream users.
package seven_seg_pkg;

  localparam int SEG_W_DEFAULT = 7;
  localparam int MAX_DIGITS    = 32;

  localparam logic [SEG_W_DEFAULT-1:0] SEG_OFF = '0;

  // Active-high gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    onehot = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/seven_seg_refresh_timer.sv
// Dwell counter for one digit; flags the advance cycle when the count reaches PERIOD.
// The count itself is only exported when SEVEN_SEG_DIMMING_EN is defined.
module seven_seg_refresh_timer
  import seven_seg_pkg::*;
#(
  parameter int PERIOD = 500,
  parameter int CBITS  = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
`ifdef SEVEN_SEG_DIMMING_EN
  output logic [CBITS-1:0] cnt,
`endif
  output logic             adv
);

  logic [CBITS-1:0] cnt_r;
  logic [CBITS-1:0] cnt_next_s;

  assign adv = enable && (cnt_r == CBITS'(PERIOD));

`ifdef SEVEN_SEG_DIMMING_EN
  assign cnt = cnt_r;
`endif

  // Next count: wrap on advance, step while enabled, otherwise hold.
  always_comb begin
    cnt_next_s = cnt_r;
    if (adv) begin
      cnt_next_s = '0;
    end else if (enable) begin
      cnt_next_s = cnt_r + CBITS'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// N-digit multiplexed seven-segment scanner with pause, per-digit blanking and frame pulse.
// Optional PWM dimming of the segment bus is enabled by defining SEVEN_SEG_DIMMING_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = SEG_W_DEFAULT,
  parameter int PERIOD     = 500,
  parameter int CBITS      = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1,
  localparam int IW        = $clog2(NUM_DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
  input  logic                        enable,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
`ifdef SEVEN_SEG_DIMMING_EN
  input  logic [CBITS-1:0]            duty,
`endif
  output logic [SEG_W-1:0]            segment,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic [IW-1:0]               digit_idx,
  output logic                        sig,
  output logic                        frame_done
);

  logic              adv_s;
  logic [IW-1:0]     idx_r;
  logic [IW-1:0]     idx_next_s;
  logic [SEG_W-1:0]  pat_s;
  logic [SEG_W-1:0]  seg_r;
  logic [NUM_DIGITS-1:0] sel_r;
  logic              sig_r;
  logic              fd_r;

`ifdef SEVEN_SEG_DIMMING_EN
  logic [CBITS-1:0]  cnt_s;
`endif

  seven_seg_refresh_timer #(
    .PERIOD (PERIOD),
    .CBITS  (CBITS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
`ifdef SEVEN_SEG_DIMMING_EN
    .cnt    (cnt_s),
`endif
    .adv    (adv_s)
  );

  // Index the scan moves to on the next advance.
  always_comb begin
    idx_next_s = idx_r;
    if (idx_r == IW'(NUM_DIGITS - 1)) begin
      idx_next_s = '0;
    end else begin
      idx_next_s = idx_r + IW'(1);
    end
  end

  // Pattern of the upcoming digit, forced dark when its blank bit is set.
  always_comb begin
    pat_s = SEG_W'(SEG_OFF);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      pat_s = pat_s | ((idx_next_s == IW'(k)) ? digits_in[k*SEG_W +: SEG_W] : SEG_W'(SEG_OFF));
    end
    if (blank_mask[idx_next_s]) begin
      pat_s = SEG_W'(SEG_OFF);
    end else begin
      pat_s = pat_s;
    end
  end

  // Scan state and registered outputs; inputs are captured only on advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= IW'(NUM_DIGITS - 1);
      seg_r <= SEG_W'(SEG_OFF);
      sel_r <= '0;
      sig_r <= 1'b0;
      fd_r  <= 1'b0;
    end else if (adv_s) begin
      idx_r <= idx_next_s;
      seg_r <= pat_s;
      sel_r <= NUM_DIGITS'(onehot(32'(idx_next_s)));
      sig_r <= 1'b1;
      fd_r  <= (idx_next_s == IW'(0));
    end else begin
      sig_r <= 1'b0;
      fd_r  <= 1'b0;
    end
  end

`ifdef SEVEN_SEG_DIMMING_EN
  assign segment = (cnt_s < duty) ? seg_r : SEG_W'(SEG_OFF);
`else
  assign segment = seg_r;
`endif

  assign digit_sel  = sel_r;
  assign digit_idx  = idx_r;
  assign sig        = sig_r;
  assign frame_done = fd_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed scoreboard bench for seven_seg_scan: 3 digits, PERIOD=4.
module tb_seven_seg_scan;

  typedef struct packed {
    logic       fd;
    logic [1:0] idx;
    logic [2:0] sel;
    logic [6:0] seg;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [20:0] digits_in;
  logic        enable;
  logic [2:0]  blank_mask;
  logic [6:0]  segment;
  logic [2:0]  digit_sel;
  logic [1:0]  digit_idx;
  logic        sig;
  logic        frame_done;
`ifdef SEVEN_SEG_DIMMING_EN
  logic [2:0]  duty;
`endif

  logic [6:0]  pat [3];
  exp_t        q [$];
  int          total;
  int          bad;

  assign digits_in = {pat[2], pat[1], pat[0]};

  seven_seg_scan #(
    .NUM_DIGITS (3),
    .SEG_W      (7),
    .PERIOD     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .enable     (enable),
    .blank_mask (blank_mask),
`ifdef SEVEN_SEG_DIMMING_EN
    .duty       (duty),
`endif
    .segment    (segment),
    .digit_sel  (digit_sel),
    .digit_idx  (digit_idx),
    .sig        (sig),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx = 2'(i);
    e.sel = 3'(1 << i);
    e.seg = blank_mask[i] ? 7'h00 : pat[i];
    e.fd  = (i == 0);
    q.push_back(e);
  endtask

  // Wait (bounded) for the advance pulse, then compare against the queued expectation.
  task automatic next_adv(input int n);
    int   edges = 0;
    exp_t e;
    do begin
      @(negedge clk);
      edges++;
    end while (sig !== 1'b1 && edges < 20);
    chk("adv_edges", 32'(edges), 32'(n));
    e = q.pop_front();
    chk("adv_seg", 32'(segment), 32'(e.seg));
    chk("adv_sel", 32'(digit_sel), 32'(e.sel));
    chk("adv_idx", 32'(digit_idx), 32'(e.idx));
    chk("adv_frame", 32'(frame_done), 32'(e.fd));
    @(negedge clk);
    chk("sig_width", 32'(sig), 32'd0);
    chk("frame_width", 32'(frame_done), 32'd0);
    chk("held_sel", 32'(digit_sel), 32'(e.sel));
  endtask

  initial begin
    int sig_seen;
    total = 0;
    bad = 0;
    rst = 1'b0;
    enable = 1'b1;
    blank_mask = 3'b000;
    pat[0] = 7'h06;
    pat[1] = 7'h5B;
    pat[2] = 7'h4F;
`ifdef SEVEN_SEG_DIMMING_EN
    duty = 3'd5;
`endif

    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(segment), 32'd0);
    chk("rst_sel", 32'(digit_sel), 32'd0);
    chk("rst_idx", 32'(digit_idx), 32'd2);
    chk("rst_sig", 32'(sig), 32'd0);
    chk("rst_frame", 32'(frame_done), 32'd0);

    rst = 1'b1;
    push_exp(0); next_adv(5);
    push_exp(1); next_adv(4);
    push_exp(2); next_adv(4);
    push_exp(0); next_adv(4);

    // Pause for 7 cycles with the count at 3.
    repeat (2) @(negedge clk);
    enable = 1'b0;
    sig_seen = 0;
    repeat (7) begin
      @(negedge clk);
      if (sig === 1'b1) sig_seen++;
    end
    chk("pause_sig", 32'(sig_seen), 32'd0);
    chk("pause_sel", 32'(digit_sel), 32'h1);
    chk("pause_seg", 32'(segment), 32'h06);
    enable = 1'b1;
    push_exp(1); next_adv(2);

    blank_mask = 3'b010;
    push_exp(2); next_adv(4);
    push_exp(0); next_adv(4);
    push_exp(1); next_adv(4);

    // Input changes mid-dwell stay invisible until the next advance.
    blank_mask = 3'b000;
    @(negedge clk);
    pat[2] = 7'h7D;
    #1;
    chk("mid_dwell_seg", 32'(segment), 32'd0);
    push_exp(2); next_adv(3);

    // Asynchronous reset mid-dwell at cnt=2.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_seg", 32'(segment), 32'd0);
    chk("async_sel", 32'(digit_sel), 32'd0);
    chk("async_idx", 32'(digit_idx), 32'd2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_exp(0); next_adv(5);

`ifdef SEVEN_SEG_DIMMING_EN
    duty = 3'd2;
    repeat (3) begin
      @(negedge clk);
      chk("dim2_off", 32'(segment), 32'd0);
    end
    push_exp(1); next_adv(1);
    duty = 3'd0;
    repeat (5) begin
      @(negedge clk);
      chk("dim0_off", 32'(segment), 32'd0);
    end
    duty = 3'd5;
    repeat (3) begin
      @(negedge clk);
      chk("dim5_on", 32'(segment), 32'(pat[2]));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
